// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage and its multiply/divide unit.
// Latency: none, constants and pure helpers only.
// Backpressure: none.
package ex_pkg;
    typedef logic [3:0] md_op_t;

    localparam md_op_t MD_NONE  = 4'd0;
    localparam md_op_t MD_MULT  = 4'd1;
    localparam md_op_t MD_MULTU = 4'd2;
    localparam md_op_t MD_DIV   = 4'd3;
    localparam md_op_t MD_DIVU  = 4'd4;
    localparam md_op_t MD_MFHI  = 4'd5;
    localparam md_op_t MD_MFLO  = 4'd6;
    localparam md_op_t MD_MTHI  = 4'd7;
    localparam md_op_t MD_MTLO  = 4'd8;

    localparam logic [1:0] DST_RD = 2'd0;
    localparam logic [1:0] DST_RT = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;
    localparam logic [1:0] DST_XP = 2'd3;

    localparam int RA_DEFAULT = 31;
    localparam int XP_DEFAULT = 26;

    localparam logic [5:0] ALU_ADD = 6'h00;
    localparam logic [5:0] ALU_SUB = 6'h01;
    localparam logic [5:0] ALU_AND = 6'h18;
    localparam logic [5:0] ALU_OR  = 6'h1E;
    localparam logic [5:0] ALU_XOR = 6'h16;
    localparam logic [5:0] ALU_NOR = 6'h11;
    localparam logic [5:0] ALU_SLL = 6'h20;
    localparam logic [5:0] ALU_SRL = 6'h21;
    localparam logic [5:0] ALU_SRA = 6'h23;
    localparam logic [5:0] ALU_SLT = 6'h35;

    function automatic logic md_is_start(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction
endpackage

// File: rtl/md_unit.sv
// Iterative radix-2 multiply/divide with HI/LO result registers.
// Latency: W cycles of busy after the start edge; HI/LO update on the edge busy falls.
// Backpressure: none internally; the caller must not start or touch HI/LO while busy.
module md_unit
    import ex_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  md_op_t       op,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         wr_hi,
    input  logic         wr_lo,
    input  logic [W-1:0] wr_data,
    output logic         busy,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [CW-1:0] cnt;
    logic          is_div, neg_lo, neg_hi, div0;
    logic [W-1:0]  acc, sh, mag_b, dvd_raw;

    logic          sgn_a, sgn_b;
    logic [W-1:0]  abs_a, abs_b;
    assign sgn_a = md_is_signed(op) && op_a[W-1];
    assign sgn_b = md_is_signed(op) && op_b[W-1];
    assign abs_a = sgn_a ? -op_a : op_a;
    assign abs_b = sgn_b ? -op_b : op_b;

    // acc:sh is the product (multiply) or remainder:quotient (divide) shift pair
    logic [W:0]     add_v, rem_sh, diff;
    logic [W-1:0]   acc_n, sh_n;
    logic [2*W-1:0] prod;
    always_comb begin
        add_v  = sh[0] ? ({1'b0, acc} + {1'b0, mag_b}) : {1'b0, acc};
        rem_sh = {acc, sh[W-1]};
        diff   = rem_sh - {1'b0, mag_b};
        if (is_div) begin
            acc_n = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
            sh_n  = {sh[W-2:0], ~diff[W]};
        end else begin
            acc_n = add_v[W:1];
            sh_n  = {add_v[0], sh[W-1:1]};
        end
        prod = {acc_n, sh_n};
        if (neg_lo) prod = -prod;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            div0    <= 1'b0;
            acc     <= '0;
            sh      <= '0;
            mag_b   <= '0;
            dvd_raw <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= '0;
            is_div  <= md_is_div(op);
            neg_lo  <= sgn_a ^ sgn_b;
            neg_hi  <= sgn_a;
            div0    <= (op_b == '0);
            dvd_raw <= op_a;
            acc     <= '0;
            sh      <= abs_a;
            mag_b   <= abs_b;
        end else if (busy) begin
            acc <= acc_n;
            sh  <= sh_n;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
                busy <= 1'b0;
                if (!is_div) begin
                    {hi, lo} <= prod;
                end else if (div0) begin
                    hi <= dvd_raw;
                    lo <= '1;
                end else begin
                    hi <= neg_hi ? -acc_n : acc_n;
                    lo <= neg_lo ? -sh_n : sh_n;
                end
            end
        end else begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
        end
    end
endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: forwarding, ALU, destination select, EX/MEM register and mult/div unit.
// Latency: 1 cycle to EX/MEM; forward outputs are combinational; mult/div takes W cycles.
// Backpressure: stall_ex holds upstream only for HI/LO users and new mult/div ops while busy.
module ex_stage_md
    import ex_pkg::*;
#(
    parameter int W       = 32,
    parameter int RA_ADDR = RA_DEFAULT,
    parameter int XP_ADDR = XP_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] pc,
    input  logic [31:0]  instr,
    input  logic [5:0]   alu_fun,
    input  logic         sign,
    input  logic         alu_src1,
    input  logic         alu_src2,
    input  logic [1:0]   reg_dst,
    input  logic         reg_wr,
    input  logic         mem_rd,
    input  logic         mem_wr,
    input  logic [1:0]   mem2reg,
    input  md_op_t       md_op,
    input  logic [W-1:0] rs_data,
    input  logic [W-1:0] rt_data,
    input  logic [W-1:0] imm_ext,
    input  logic         reg_wr_w,
    input  logic [4:0]   addr_w,
    input  logic [W-1:0] data_w,
    output logic         stall_ex,
    output logic         md_busy,
    output logic [4:0]   rt_e,
    output logic [4:0]   addr_e2fwd,
    output logic [W-1:0] data_e2fwd,
    output logic         valid_m,
    output logic [W-1:0] data_m,
    output logic [W-1:0] pc_mem,
    output logic [W-1:0] store_data_m,
    output logic         mem_rd_m,
    output logic         mem_wr_m,
    output logic         reg_wr_m,
    output logic [1:0]   mem2reg_m,
    output logic [4:0]   addr_m
);
    localparam int SW = $clog2(W);

    logic [4:0] rs, rt, rd, shamt;
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign rt_e  = rt;

    logic unused_instr;
    assign unused_instr = ^{instr[31:26], instr[5:0]};

    // MEM result wins over WB; register 0 is never forwarded
    logic         hit_m_a, hit_w_a, hit_m_b, hit_w_b;
    logic [W-1:0] fwd_a, fwd_b;
    assign hit_m_a = valid_m && reg_wr_m && (addr_m != 5'd0) && (addr_m == rs);
    assign hit_w_a = reg_wr_w && (addr_w != 5'd0) && (addr_w == rs);
    assign hit_m_b = valid_m && reg_wr_m && (addr_m != 5'd0) && (addr_m == rt);
    assign hit_w_b = reg_wr_w && (addr_w != 5'd0) && (addr_w == rt);
    assign fwd_a   = hit_m_a ? data_m : (hit_w_a ? data_w : rs_data);
    assign fwd_b   = hit_m_b ? data_m : (hit_w_b ? data_w : rt_data);

    logic [W-1:0]  alu_a, alu_b, aluout;
    logic [SW-1:0] sh_amt;
    assign alu_a  = alu_src1 ? W'(shamt) : fwd_a;
    assign alu_b  = alu_src2 ? imm_ext : fwd_b;
    assign sh_amt = alu_a[SW-1:0];

    always_comb begin
        case (alu_fun)
            ALU_ADD: aluout = alu_a + alu_b;
            ALU_SUB: aluout = alu_a - alu_b;
            ALU_AND: aluout = alu_a & alu_b;
            ALU_OR:  aluout = alu_a | alu_b;
            ALU_XOR: aluout = alu_a ^ alu_b;
            ALU_NOR: aluout = ~(alu_a | alu_b);
            ALU_SLL: aluout = alu_b << sh_amt;
            ALU_SRL: aluout = alu_b >> sh_amt;
            ALU_SRA: aluout = $unsigned($signed(alu_b) >>> sh_amt);
            ALU_SLT: aluout = W'(sign ? ($signed(alu_a) < $signed(alu_b)) : (alu_a < alu_b));
            default: aluout = '0;
        endcase
    end

    logic [W-1:0] hi, lo;
    always_comb begin
        case (md_op)
            MD_MFHI: data_e2fwd = hi;
            MD_MFLO: data_e2fwd = lo;
            default: data_e2fwd = aluout;
        endcase
        case (reg_dst)
            DST_RD:  addr_e2fwd = rd;
            DST_RT:  addr_e2fwd = rt;
            DST_RA:  addr_e2fwd = 5'(RA_ADDR);
            default: addr_e2fwd = 5'(XP_ADDR);
        endcase
    end

    logic issue, md_start;
    assign stall_ex = in_valid && md_busy && (md_op != MD_NONE);
    assign issue    = in_valid && !stall_ex;
    assign md_start = in_valid && md_is_start(md_op) && !md_busy;

    md_unit #(.W(W)) u_md (
        .clk     (clk),
        .reset   (reset),
        .start   (md_start),
        .op      (md_op),
        .op_a    (fwd_a),
        .op_b    (fwd_b),
        .wr_hi   (issue && (md_op == MD_MTHI)),
        .wr_lo   (issue && (md_op == MD_MTLO)),
        .wr_data (fwd_a),
        .busy    (md_busy),
        .hi      (hi),
        .lo      (lo)
    );

    // The mult/div start itself writes nothing back; its result lands in HI/LO later
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_m      <= 1'b0;
            data_m       <= '0;
            pc_mem       <= '0;
            store_data_m <= '0;
            mem_rd_m     <= 1'b0;
            mem_wr_m     <= 1'b0;
            reg_wr_m     <= 1'b0;
            mem2reg_m    <= '0;
            addr_m       <= '0;
        end else begin
            valid_m      <= issue;
            reg_wr_m     <= issue && reg_wr && !md_start;
            mem_rd_m     <= issue && mem_rd;
            mem_wr_m     <= issue && mem_wr;
            data_m       <= data_e2fwd;
            pc_mem       <= pc;
            store_data_m <= fwd_b;
            mem2reg_m    <= mem2reg;
            addr_m       <= addr_e2fwd;
        end
    end
endmodule
